// File: rtl/jtcop_coin.sv
// jtcop_coin_cond
//   Conditions the cabinet coin and service switches for the decoder read path.
//   Each switch is synchronised and debounced. Every accepted coin becomes a
//   frame-aligned active-low pulse of PULSEF frames, followed by a gap of GAPF
//   frames. Coins inserted while a pulse is running are queued, up to QMAX per
//   slot.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   LVBL         vertical blank (active low); its falling edge is the frame tick
//   coin_raw     raw coin switches (active low, asynchronous)
//   service_raw  raw service switch (active low, asynchronous)
//   coin_input   conditioned coins to the decoder (active low)
//   service      conditioned service level (active low)
//   coin_ctr     one-clk coin-counter pulse per coin that starts playing
//   dropped      one-clk strobe when a coin is lost because the queue is full

// Two-flop synchroniser followed by a hold-time filter. A mismatch must persist
// for DEBOUNCE consecutive clocks; any return to the filtered level restarts it.
module jtcop_coin_filter #(
    parameter int              DEBW     = 16,
    parameter logic [DEBW-1:0] DEBOUNCE = 16'd2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);
    localparam logic [DEBW-1:0] DEB_LAST = DEBW'(DEBOUNCE - 1);

    logic [1:0]      sync;
    logic [DEBW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + DEBW'(1);
            end
        end
    end
endmodule

// One coin slot: the pending-coin queue counter and the pulse FSM.
module jtcop_coin_slot #(
    parameter logic [2:0] PULSEF = 3'd3,
    parameter logic [2:0] GAPF   = 3'd1,
    parameter logic [1:0] QMAX   = 2'd3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic press,
    output logic coin_n,
    output logic ctr,
    output logic drop
);
    typedef enum logic [1:0] { IDLE, ACT, GAP } state_t;

    state_t     st, st_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic [1:0] q, q_nxt;
    logic       deq, acc, drp;

    always_comb begin
        st_nxt   = st;
        fcnt_nxt = fcnt;
        deq      = 1'b0;
        if (tick) begin
            case (st)
                IDLE: if (q != 2'd0) begin
                    st_nxt   = ACT;
                    fcnt_nxt = PULSEF - 3'd1;
                    deq      = 1'b1;
                end
                ACT: if (fcnt == 3'd0) begin
                    st_nxt   = GAP;
                    fcnt_nxt = GAPF - 3'd1;
                end else begin
                    fcnt_nxt = fcnt - 3'd1;
                end
                // When the gap ends with coins waiting, pass through IDLE on the
                // same tick so the high time between queued coins is exactly GAPF.
                GAP: if (fcnt != 3'd0) begin
                    fcnt_nxt = fcnt - 3'd1;
                end else if (q != 2'd0) begin
                    st_nxt   = ACT;
                    fcnt_nxt = PULSEF - 3'd1;
                    deq      = 1'b1;
                end else begin
                    st_nxt   = IDLE;
                end
                default: st_nxt = IDLE;
            endcase
        end
        // A dequeue on the same clock frees a slot, so a press with a full
        // queue is still accepted then.
        acc   = press & ((q < QMAX) | deq);
        drp   = press & ~acc;
        q_nxt = q;
        if (acc & ~deq)      q_nxt = q + 2'd1;
        else if (~acc & deq) q_nxt = q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            fcnt   <= 3'd0;
            q      <= 2'd0;
            coin_n <= 1'b1;
            ctr    <= 1'b0;
            drop   <= 1'b0;
        end else begin
            st     <= st_nxt;
            fcnt   <= fcnt_nxt;
            q      <= q_nxt;
            coin_n <= (st_nxt != ACT);
            ctr    <= deq;
            drop   <= drp;
        end
    end
endmodule

module jtcop_coin_cond #(
    parameter int              DEBW     = 16,
    parameter logic [DEBW-1:0] DEBOUNCE = 16'd2000,
    parameter logic [2:0]      PULSEF   = 3'd3,
    parameter logic [2:0]      GAPF     = 3'd1,
    parameter logic [1:0]      QMAX     = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       LVBL,
    input  logic [1:0] coin_raw,
    input  logic       service_raw,
    output logic [1:0] coin_input,
    output logic       service,
    output logic [1:0] coin_ctr,
    output logic [1:0] dropped
);
    logic       LVBL_l, tick;
    logic [1:0] coin_f, coin_fl, press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LVBL_l  <= 1'b1;
            coin_fl <= 2'b11;
        end else begin
            LVBL_l  <= LVBL;
            coin_fl <= coin_f;
        end
    end

    assign tick  = LVBL_l & ~LVBL;
    assign press = coin_fl & ~coin_f;   // filtered falling edge: one per hold

    jtcop_coin_filter #(.DEBW(DEBW), .DEBOUNCE(DEBOUNCE)) u_srv (
        .clk(clk), .rst_n(rst_n), .raw(service_raw), .filt(service)
    );

    genvar n;
    generate
        for (n = 0; n < 2; n++) begin : g_slot
            jtcop_coin_filter #(.DEBW(DEBW), .DEBOUNCE(DEBOUNCE)) u_flt (
                .clk(clk), .rst_n(rst_n), .raw(coin_raw[n]), .filt(coin_f[n])
            );
            jtcop_coin_slot #(.PULSEF(PULSEF), .GAPF(GAPF), .QMAX(QMAX)) u_slot (
                .clk(clk), .rst_n(rst_n), .tick(tick), .press(press[n]),
                .coin_n(coin_input[n]), .ctr(coin_ctr[n]), .drop(dropped[n])
            );
        end
    endgenerate
endmodule
